led_pwm_fader: RTL
==================

Name: led_pwm_fader

Overview:
Downstream consumer of the 8-bit LED PIO register output. Turns each on/off bit into a smoothly ramped PWM brightness, so that software writes to the LED PIO fade in and out instead of switching hard. Sits between the PIO output port and the board LED pins. It is purely a streaming/timing stage with no bus interface.

Parameters:
N_LEDS, 8, number of LED channels; matches the PIO output width.
PWM_BITS, 8, brightness and PWM counter width; LEVEL_MAX = 2**PWM_BITS-1.
STEP_DIV, 50000, clk cycles per brightness step; legal range >= 1. The bench uses 4.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
led_in  in  N_LEDS  target on/off pattern from the LED PIO register
fade_en  in  1  1 = ramp brightness; 0 = snap brightness immediately
led_out  out  N_LEDS  PWM drive to the LED pins, registered
settled  out  1  1 when every channel level equals its target, registered

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-high.
- Reset values:
  - led_in_q = 0, all level[i] = 0, pwm_cnt = 0, presc = 0.
  - led_out = 0, settled = 1.
- Input stage: led_in_q <= led_in every cycle, giving 1 cycle of latency. fade_en is registered the same way (fade_en_q).
- Prescaler:
  - presc counts 0..STEP_DIV-1, then wraps to 0.
  - step_tick = (presc == STEP_DIV-1), combinational.
  - When STEP_DIV = 1, step_tick is permanently 1.
- PWM counter: pwm_cnt increments every cycle and wraps LEVEL_MAX -> 0, giving a period of 2**PWM_BITS cycles.
- Target: target[i] = led_in_q[i] ? LEVEL_MAX : 0.
- Level update per channel, priority order:
  1. fade_en_q = 0: level[i] <= target[i] on the next cycle (snap).
  2. Else, on step_tick:
     - led_in_q[i] = 1 and level < LEVEL_MAX: level + 1.
     - led_in_q[i] = 0 and level > 0: level - 1.
     - Otherwise hold (saturating; never wraps).
  3. Else hold.
- Direction reversal mid-ramp: the level continues from its current value in the new direction at the next step_tick. No jump, no restart.
- Output:
  - led_out[i] <= (level[i] == LEVEL_MAX) | (level[i] > pwm_cnt), registered.
  - level 0 -> constantly 0. level LEVEL_MAX -> constantly 1.
  - Otherwise high for exactly level cycles per PWM period.
- settled: settled <= AND over i of (level[i] == target[i]), registered.
- Latency, snap mode: led_in change -> led_out reflects it after 3 clk edges (input reg, level, output reg). settled is high on the same edge.
- Latency, fade mode: the first level step happens on the first step_tick after led_in_q updates. A full ramp takes LEVEL_MAX step_ticks, i.e. 255*STEP_DIV cycles at defaults.
- Simultaneous events:
  - A fade_en falling edge coinciding with step_tick: snap wins.
  - A led_in change coinciding with step_tick: that tick uses the old led_in_q.
- Mid-operation reset: all state returns to reset values immediately, asynchronously. After deassertion the channels ramp or snap from 0 toward the current led_in.
- The PIO reset pattern 0xAA therefore fades in after reset when fade_en = 1.

Decomposition:
- Package led_fader_pkg holds:
  - PWM_BITS_DEFAULT and the LEVEL_MAX function/constant.
  - The level type (logic [PWM_BITS-1:0]).
- One sub-module, led_fade_channel, instantiated N_LEDS times.
  - Contains: level register, saturating up/down step, snap logic, compare against the shared pwm_cnt, led_out flop.
  - Outputs an at_target flag.
- The top holds the input registers, prescaler, pwm_cnt and the settled AND-reduction.

Test Plan:
1. Reset: assert reset mid-ramp with level[0] = 100 -> led_out = 0x00 and settled = 1 immediately, asynchronously. After release with led_in = 0x00, outputs stay 0 and settled stays 1.
2. Snap: fade_en = 1'b0, led_in 0x00 -> 0xAA -> led_out = 0xAA constantly from the 3rd edge onward; settled never drops below 1 for more than 2 cycles.
3. Fade-up (STEP_DIV = 4): fade_en = 1, led_in = 0x01 ->
   - settled = 0 until level[0] = 255 after 1020 cycles (±3), then settled = 1.
   - led_out[0] thereafter constant 1.
   - Bits 7:1 stay 0.
4. Duty: during the fade-up, hold at level[0] = 128 by driving STEP_DIV large -> over 256 cycles led_out[0] is high for exactly 128 cycles. At level 1: exactly 1 cycle.
5. Reversal: at level[0] = 100, led_in -> 0x00 -> the next step gives 99 (no jump). It reaches 0 after 100 further step_ticks, then led_out[0] = 0 constantly and settled = 1.
6. Saturation plus mode switch:
   - Hold led_in = 0xFF for 2000 extra cycles at LEVEL_MAX -> all levels stay 255 (no wrap).
   - Then set led_in = 0x00 and, at the same time as a step_tick, drop fade_en to 0 -> all levels 0 within 2 cycles and led_out = 0x00.

Source files
------------

// File: rtl/led_fader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_fader_pkg
//  Brief    : Shared widths, brightness ceiling helper and level type for the
//             LED PWM fader.
//  Revision : 1.0 - initial release
// ============================================================================
package led_fader_pkg;

    localparam int PWM_BITS_DEFAULT = 8;

    // Full-brightness code for a given PWM width
    function automatic int level_max_f(input int bits);
        return (1 << bits) - 1;
    endfunction

    localparam int LEVEL_MAX_DEFAULT = level_max_f(PWM_BITS_DEFAULT);

    typedef logic [PWM_BITS_DEFAULT-1:0] level_t;

endpackage
`default_nettype wire

// File: rtl/led_fade_channel.sv
`default_nettype none
// ============================================================================
//  Module   : led_fade_channel
//  Brief    : One LED channel: saturating brightness ramp or snap, PWM compare
//             against the shared counter, registered pin drive.
//  Revision : 1.0 - initial release
// ============================================================================
module led_fade_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                led_on,
    input  logic                fade_en,
    input  logic                step_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_out,
    output logic                at_target
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(level_max_f(PWM_BITS));
    localparam logic [PWM_BITS-1:0] LEVEL_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_target;
    logic [PWM_BITS-1:0] w_level_next;
    logic                r_led_out;

    assign w_target = led_on ? LEVEL_MAX : '0;

    // Snap has priority over stepping; stepping saturates at both ends
    always_comb begin
        w_level_next = r_level;
        if (!fade_en) begin
            w_level_next = w_target;
        end else if (step_tick) begin
            if (led_on && (r_level != LEVEL_MAX)) begin
                w_level_next = r_level + LEVEL_ONE;
            end else if (!led_on && (r_level != '0)) begin
                w_level_next = r_level - LEVEL_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_next;
        end
    end

    // Full scale forces the pin solidly on instead of 255/256 duty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led_out <= 1'b0;
        end else begin
            r_led_out <= (r_level == LEVEL_MAX) | (r_level > pwm_cnt);
        end
    end

    assign led_out   = r_led_out;
    assign at_target = (r_level == w_target);

endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module   : led_pwm_fader
//  Brief    : Turns LED PIO on/off bits into PWM brightness that ramps (or
//             snaps) toward the requested state.
//  Revision : 1.0 - initial release
// ============================================================================
module led_pwm_fader
    import led_fader_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = PWM_BITS_DEFAULT,
    parameter int STEP_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_LEDS-1:0] led_in,
    input  logic              fade_en,
    output logic [N_LEDS-1:0] led_out,
    output logic              settled
);

    localparam int                  PRESC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE    = PWM_BITS'(1);

    logic [N_LEDS-1:0]   r_led_in_q;
    logic                r_fade_en_q;
    logic [PRESC_W-1:0]  r_presc;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_settled;
    logic                w_step_tick;
    logic [N_LEDS-1:0]   w_at_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led_in_q  <= '0;
            r_fade_en_q <= 1'b0;
        end else begin
            r_led_in_q  <= led_in;
            r_fade_en_q <= fade_en;
        end
    end

    // With STEP_DIV = 1 the counter sits at 0 and every cycle is a step
    assign w_step_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_step_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
        end
    end

    generate
        for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
            led_fade_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .led_on    (r_led_in_q[i]),
                .fade_en   (r_fade_en_q),
                .step_tick (w_step_tick),
                .pwm_cnt   (r_pwm_cnt),
                .led_out   (led_out[i]),
                .at_target (w_at_target[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settled <= 1'b1;
        end else begin
            r_settled <= &w_at_target;
        end
    end

    assign settled = r_settled;

endmodule
`default_nettype wire
